// File: rtl/codec_sample_feeder.sv
// codec_sample_feeder: elastic FIFO between the flash playback FSM and the
// audio codec. Samples are attenuated, left-justified into the codec word and
// written with single-cycle strobes. Underrun episodes and dropped pushes are
// recorded.
module codec_sample_feeder #(
   parameter int DEPTH    = 8,
   parameter int SAMPLE_W = 16,
   parameter int CODEC_W  = 24,
   parameter int LVL_W    = $clog2(DEPTH) + 1
) (
   input  logic                CLK50MHZ,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   output logic                sample_ready,
   input  logic                pause,
   input  logic [2:0]          atten,
   input  logic                codec_write_ready,
   output logic                codec_write,
   output logic [CODEC_W-1:0]  codec_writedata_left,
   output logic [CODEC_W-1:0]  codec_writedata_right,
   output logic [LVL_W-1:0]    fifo_level,
   output logic [15:0]         underrun_count,
   output logic                overflow
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, HOLD} state_t;

   state_t                     state_q, state_d;
   logic [SAMPLE_W-1:0]        mem_q [DEPTH];
   logic [SAMPLE_W-1:0]        mem_d [DEPTH];
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]           level_q, level_d;
   logic [SAMPLE_W-1:0]        data_q, data_d;
   logic [CODEC_W-1:0]         word_q, word_d;
   logic                       write_q, write_d;
   logic [15:0]                under_q, under_d;
   logic                       episode_q, episode_d;
   logic                       ovf_q, ovf_d;

   logic                       empty, full, pop, push, under_cond;
   logic signed [SAMPLE_W-1:0] shifted;

   // FIFO status, push/pop decisions and the attenuated sample
   always_comb begin
      empty      = (level_q == '0);
      full       = (level_q == LVL_W'(DEPTH));
      pop        = (state_q == IDLE) && !empty && !pause;
      // a full FIFO still accepts a push when the head leaves in the same cycle
      push       = sample_valid && (!full || pop);
      under_cond = (state_q == IDLE) && empty && !pause && codec_write_ready;
      shifted    = $signed(data_q) >>> atten;
   end

   // next-state logic for FIFO storage, pointers, level and counters
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         mem_d[wr_ptr_q] = sample_in;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
         level_d = level_q - LVL_W'(1);
      end

      ovf_d = ovf_q || (sample_valid && !push);

      // one count per episode; the episode flag is cleared by the next push
      under_d = under_q;
      if (under_cond && !episode_q && (under_q != 16'hFFFF)) begin
         under_d = under_q + 16'd1;
      end
      if (push) begin
         episode_d = 1'b0;
      end else if (under_cond) begin
         episode_d = 1'b1;
      end else begin
         episode_d = episode_q;
      end
   end

   // write sequencer: pop -> load/format -> wait for ready -> strobe
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      word_d  = word_q;
      write_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pop) begin
               data_d  = mem_q[rd_ptr_q];
               state_d = LOAD;
            end
         end
         LOAD: begin
            word_d  = {shifted, {(CODEC_W-SAMPLE_W){1'b0}}};
            state_d = WRITE;
         end
         WRITE: begin
            if (codec_write_ready) begin
               write_d = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // control, sequencer and counter registers with synchronous reset
   always_ff @(posedge CLK50MHZ) begin
      if (reset) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         data_q    <= '0;
         word_q    <= '0;
         write_q   <= 1'b0;
         under_q   <= '0;
         episode_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         data_q    <= data_d;
         word_q    <= word_d;
         write_q   <= write_d;
         under_q   <= under_d;
         episode_q <= episode_d;
         ovf_q     <= ovf_d;
      end
   end

   // sample storage; contents are don't-care until written
   always_ff @(posedge CLK50MHZ) begin
      mem_q <= mem_d;
   end

   assign sample_ready          = !full;
   assign codec_write           = write_q;
   assign codec_writedata_left  = word_q;
   assign codec_writedata_right = word_q;
   assign fifo_level            = level_q;
   assign underrun_count        = under_q;
   assign overflow              = ovf_q;

endmodule
